// File: rtl/key_scan.sv
// key_scan: 4x5 keypad matrix scanner and frame-based debouncer.
// Drives one column per slot, samples the rows at the end of each slot,
// resolves the lowest pressed key code per frame and debounces it across
// whole frames. The result is a single-cycle key event for the timer FSM.
// Optional build macro KEY_REPEAT_EN adds auto-repeat events while a key is held.
module key_scan #(
    parameter int SCAN_DIV        = 2500,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_key_in,
    output logic [3:0] o_key_out,
    output logic [4:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_held
);

    localparam int              SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [7:0]      DF_CNT    = 8'(DEBOUNCE_FRAMES);

    // Reject configurations the scan/debounce logic cannot honour.
    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 255 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("key_scan: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAND    = 2'd1,
        S_PRESSED = 2'd2,
        S_RELCHK  = 2'd3
    } state_t;

    // Index of the lowest set row, so the lowest code in a column wins.
    function automatic logic [2:0] lowest_row(input logic [4:0] rows);
        lowest_row = 3'd0;
        for (int r = 4; r >= 0; r--) begin
            if (rows[r]) lowest_row = 3'(r);
        end
    endfunction

    logic [4:0]        key_sync_p0, key_sync_p1;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic              acc_vld;
    logic [4:0]        acc_code;
    logic              sample, frame_end, row_hit, res_vld;
    logic [4:0]        col_code, res_code;

    state_t     state, state_n;
    logic [4:0] cand, cand_n;
    logic [7:0] cnt, cnt_n, cnt_inc;
    logic [4:0] code_n;
    logic       valid_n, held_n;

`ifdef KEY_REPEAT_EN
    localparam int HOLD_W = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [HOLD_W-1:0] DELAY_CNT = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] RATE_CNT  = HOLD_W'(REPEAT_RATE);
    logic [HOLD_W-1:0] hold_cnt, hold_n, hold_inc;
    logic              rep_first, rep_first_n;
`endif

    // Stage p0/p1: two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge i_clk) begin
        key_sync_p0 <= i_key_in;
        key_sync_p1 <= key_sync_p0;
    end

    assign sample    = (slot_cnt == SLOT_LAST);
    assign frame_end = sample && (col_idx == 2'd3);
    assign row_hit   = |key_sync_p1;
    assign col_code  = 5'({3'b000, col_idx} * 5'd5) + {2'b00, lowest_row(key_sync_p1)};
    assign res_vld   = acc_vld | row_hit;
    assign res_code  = acc_vld ? acc_code : col_code;
    assign o_key_out = 4'b0001 << col_idx;
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // Slot timing, column rotation and per-frame accumulation of the first hit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            acc_vld  <= 1'b0;
            acc_code <= 5'd0;
        end else if (sample) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            if (col_idx == 2'd0) begin
                acc_vld  <= row_hit;
                acc_code <= col_code;
            end else if (!acc_vld && row_hit) begin
                acc_vld  <= 1'b1;
                acc_code <= col_code;
            end
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Debounce FSM state and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cand        <= 5'd0;
            cnt         <= 8'd0;
            o_key_code  <= 5'd0;
            o_key_valid <= 1'b0;
            o_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            hold_cnt    <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            cnt         <= cnt_n;
            o_key_code  <= code_n;
            o_key_valid <= valid_n;
            o_key_held  <= held_n;
`ifdef KEY_REPEAT_EN
            hold_cnt    <= hold_n;
            rep_first   <= rep_first_n;
`endif
        end
    end

`ifdef KEY_REPEAT_EN
    assign hold_inc = hold_cnt + HOLD_W'(1);
`endif

    // Debounce next-state: evaluated only on the frame-end cycle.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        code_n  = o_key_code;
        valid_n = 1'b0;
        held_n  = o_key_held;
`ifdef KEY_REPEAT_EN
        hold_n      = hold_cnt;
        rep_first_n = rep_first;
`endif
        if (frame_end) begin
            unique case (state)
                S_IDLE: begin
                    if (res_vld) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = S_PRESSED;
                            code_n  = res_code;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = 8'd0;
`ifdef KEY_REPEAT_EN
                            hold_n      = '0;
                            rep_first_n = 1'b1;
`endif
                        end else begin
                            state_n = S_CAND;
                            cand_n  = res_code;
                            cnt_n   = 8'd1;
                        end
                    end
                end
                S_CAND: begin
                    if (res_vld && res_code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DF_CNT) begin
                            state_n = S_PRESSED;
                            code_n  = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = 8'd0;
`ifdef KEY_REPEAT_EN
                            hold_n      = '0;
                            rep_first_n = 1'b1;
`endif
                        end
                    end else if (res_vld) begin
                        cand_n = res_code;
                        cnt_n  = 8'd1;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = 8'd0;
                    end
                end
                S_PRESSED: begin
                    if (res_vld) begin
                        cnt_n = 8'd0;
`ifdef KEY_REPEAT_EN
                        if (hold_inc == (rep_first ? DELAY_CNT : RATE_CNT)) begin
                            valid_n     = 1'b1;
                            hold_n      = '0;
                            rep_first_n = 1'b0;
                        end else begin
                            hold_n = hold_inc;
                        end
`endif
                    end else begin
`ifdef KEY_REPEAT_EN
                        hold_n      = '0;
                        rep_first_n = 1'b1;
`endif
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = S_IDLE;
                            held_n  = 1'b0;
                            cnt_n   = 8'd0;
                        end else begin
                            state_n = S_RELCHK;
                            cnt_n   = 8'd1;
                        end
                    end
                end
                S_RELCHK: begin
                    if (res_vld) begin
                        state_n = S_PRESSED;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DF_CNT) begin
                            state_n = S_IDLE;
                            held_n  = 1'b0;
                            cnt_n   = 8'd0;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: scoreboard bench for key_scan with a 4x5 key matrix model.
module tb_key_scan;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] pressed = '0;
    logic [4:0]  key_in;
    logic [3:0]  key_out;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_held;

    typedef struct {
        int code;
        int at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc;

    key_scan #(
        .SCAN_DIV(SD),
        .DEBOUNCE_FRAMES(DF),
        .REPEAT_DELAY(5),
        .REPEAT_RATE(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_key_in(key_in),
        .o_key_out(key_out),
        .o_key_code(key_code),
        .o_key_valid(key_valid),
        .o_key_held(key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads high when a pressed key sits in the driven column.
    always_comb begin
        key_in = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 5; r++)
                if (key_out[c] && pressed[c*5+r]) key_in[r] = 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every key event is matched against the next expected one.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL event: unexpected pulse code=%0d at cycle %0d, none required", key_code, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (key_code != 5'(e.code) || cyc != e.at) begin
                    fails++;
                    $display("FAIL event: got code=%0d at cycle %0d, required code=%0d at cycle %0d",
                             key_code, cyc, e.code, e.at);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic next_frames(input int n);
        repeat (n * FR) @(negedge clk);
    endtask

    task automatic expect_event(input int code, input int frames_ahead);
        exp_t e;
        e.code = code;
        e.at   = cyc + frames_ahead * FR;
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out"},   int'(key_out),   1);
        check({tag, "_code"},  int'(key_code),  0);
        check({tag, "_valid"}, int'(key_valid), 0);
        check({tag, "_held"},  int'(key_held),  0);
    endtask

    task automatic press_seq();
        int codes[3] = '{1, 3, 9};
        for (int i = 0; i < 3; i++) begin
            expect_event(codes[i], DF);
            pressed[codes[i]] = 1'b1;
            next_frames(5);
            check("seq_code", int'(key_code), codes[i]);
            pressed = '0;
            next_frames(10);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        // Column rotation, each value held SD cycles.
        for (int k = 0; k < 2 * FR; k++) begin
            check("scan", int'(key_out), 1 << ((k / SD) % 4));
            @(negedge clk);
        end

`ifdef KEY_REPEAT_EN
        expect_event(15, DF);
        expect_event(15, DF + 5);
        expect_event(15, DF + 7);
        expect_event(15, DF + 9);
        expect_event(15, DF + 11);
        pressed[15] = 1'b1;
        next_frames(DF + 11);
        pressed = '0;
        next_frames(5);
        check("rep_held", int'(key_held), 0);
`else
        // Single press of key 15, held for 20 frames.
        expect_event(15, DF);
        pressed[15] = 1'b1;
        next_frames(20);
        check("single_held", int'(key_held), 1);
        check("single_code", int'(key_code), 15);
        pressed = '0;
        next_frames(DF - 1);
        check("release_wait", int'(key_held), 1);
        next_frames(1);
        check("release_done", int'(key_held), 0);
        next_frames(2);

        press_seq();

        // Bounce on key 9, then stable hold, then a single-frame dropout.
        for (int i = 0; i < 6; i++) begin
            pressed[9] = (i % 2 == 0);
            next_frames(1);
        end
        expect_event(9, DF);
        pressed[9] = 1'b1;
        next_frames(6);
        pressed[9] = 1'b0;
        next_frames(1);
        pressed[9] = 1'b1;
        next_frames(3);
        check("dropout_held", int'(key_held), 1);
        pressed = '0;
        next_frames(DF);
        check("bounce_rel", int'(key_held), 0);
        next_frames(2);

        // Simultaneous 3 and 12, then 12 added while 3 is held.
        expect_event(3, DF);
        pressed[3]  = 1'b1;
        pressed[12] = 1'b1;
        next_frames(5);
        check("simul_code", int'(key_code), 3);
        pressed = '0;
        next_frames(5);
        expect_event(3, DF);
        pressed[3] = 1'b1;
        next_frames(4);
        pressed[12] = 1'b1;
        next_frames(5);
        check("norollover_code", int'(key_code), 3);
        check("norollover_held", int'(key_held), 1);
        pressed = '0;
        next_frames(5);

        // Async reset during candidate counting.
        pressed[15] = 1'b1;
        next_frames(1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_cand");
        pressed = '0;
        @(negedge clk);
        rst = 1'b0;
        next_frames(5);

        // Async reset while a key is accepted and held.
        expect_event(9, DF);
        pressed[9] = 1'b1;
        next_frames(4);
        repeat (6) @(negedge clk);
        check("pre_rst_held", int'(key_held), 1);
        check("pre_rst_code", int'(key_code), 9);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_pressed");
        pressed = '0;
        @(negedge clk);
        rst = 1'b0;
        next_frames(5);
`endif

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_event: got no pulse, required code=%0d at cycle %0d", e.code, e.at);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- Keypad matrix scanner and debouncer inside timer_top, directly upstream of the timer control logic.
- Drives the 4 column lines, samples the 5 row lines, and resolves one pressed key per scan frame.
- Debounces the key across whole frames and emits a single-cycle key event with a 5-bit key code for the timer FSM.

Parameters:
SCAN_DIV, 2500, clock cycles per column slot (10 MHz clock gives 250 us per column, 1 ms per frame)
DEBOUNCE_FRAMES, 8, consecutive identical frames needed to accept a press or a release (range 1..255)
REPEAT_DELAY, 500, frames held before the first auto-repeat event (KEY_REPEAT_EN only)
REPEAT_RATE, 100, frames between later auto-repeat events (KEY_REPEAT_EN only)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_key_in  input  5  row lines from matrix; bit r high = key in driven column, row r, is pressed
o_key_out  output  4  column select, one-hot active-high
o_key_code  output  5  accepted key code, 0..19; held until the next accepted press
o_key_valid  output  1  single-cycle pulse per accepted key event
o_key_held  output  1  level, high while an accepted key is still down

Behaviour:
- Reset (async, active-high): o_key_out=4'b0001, o_key_code=0, o_key_valid=0, o_key_held=0, all counters 0, FSM=IDLE. Reset asserted mid-scan or mid-press aborts immediately, with no event on release of reset.
- i_key_in passes a 2-flop synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1. On wrap, column index advances 0->1->2->3->0 and o_key_out rotates left one-hot.
- Rows are sampled on the last cycle of each slot (slot count = SCAN_DIV-1), which gives settling time after the column change.
- Frame = 4 slots. The frame result is computed on the sample of column 3.
- Key code = col*5 + row.
- If several bits are set in a frame, the lowest code wins.
- Frame result is either NONE or one code.
- Debounce FSM, evaluated once per frame end:
  - IDLE: result NONE -> stay. Result code K -> CAND, cand=K, cnt=1.
  - CAND: result == cand -> cnt+1. When cnt reaches DEBOUNCE_FRAMES -> PRESSED, o_key_code=cand, o_key_valid pulses for 1 cycle, o_key_held=1. Result differs (other code or NONE) -> restart: a code gives CAND with cnt=1, NONE gives IDLE.
  - PRESSED: any non-NONE result (same or different key) resets release count to 0. NONE -> RELCHK, cnt=1.
  - RELCHK: NONE -> cnt+1. When cnt reaches DEBOUNCE_FRAMES -> IDLE, o_key_held=0. Non-NONE -> back to PRESSED, with no new event.
- DEBOUNCE_FRAMES=1 accepts on the first frame: IDLE goes straight to PRESSED with no CAND dwell.
- Latency: a clean press produces o_key_valid in the cycle after the frame end on which the count is met. Counted from the first frame that sees the key, that is (DEBOUNCE_FRAMES-1) frames + 1 cycle.
- o_key_valid and the o_key_code update occur in the same cycle.
- No rollover: a second key pressed while one is held gives no event until full release.
- Counters saturate and never wrap. Slot counter width is clog2(SCAN_DIV).

Optional Feature:
Macro: KEY_REPEAT_EN
- Defined: in PRESSED, a hold counter counts frames. At REPEAT_DELAY, an extra o_key_valid pulse is issued with the same code; after that, one pulse every REPEAT_RATE frames. The counter clears on entry to RELCHK and does not count while in RELCHK.
- Undefined: exactly one event per press. The hold counter logic and the REPEAT_* parameters have no effect.

Test Plan:
- Reset and scan (SCAN_DIV=4): release i_rst -> o_key_out sequence 0001,0010,0100,1000,0001, each value held 4 cycles. o_key_valid stays 0 with no keys pressed.
- Single press (SCAN_DIV=4, DEBOUNCE_FRAMES=3): key code 15 (col 3, row 0) held 20 frames -> exactly one o_key_valid pulse, o_key_code=15, o_key_held=1. o_key_held falls 3 frames after release.
- Sequence 1, 3, 9 with gaps of 10 frames: exactly 3 pulses, with codes 1, 3, 9 in order.
- Bounce: key 9 toggled on/off every frame for 6 frames, then held -> no pulse during toggling, one pulse 3 frames after stable hold begins. A 1-frame dropout while PRESSED -> no second pulse.
- Simultaneous keys 3 and 12 pressed together -> code 3 reported. Then press 12 while 3 is held -> no event.
- Async reset mid-CAND, then mid-PRESSED -> outputs return to reset values immediately. KEY_REPEAT_EN with REPEAT_DELAY=5, REPEAT_RATE=2, hold 11 frames after accept -> pulses at accept, +5, +7, +9, +11 frames.
